// File: rtl/rst_ce_seq_pkg.sv
// Shared types and helpers for the reset / clock-enable sequencer.
//   state_t   : sequencer phase (RESET, GAP, ENABLE, RUN)
//   cnt_width : counter width wide enough to hold the largest phase length
package rst_ce_seq_pkg;

    typedef enum logic [1:0] {
        RESET  = 2'd0,
        GAP    = 2'd1,
        ENABLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    // Width needed to hold max(a, b, c) as an unsigned count.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return 32'($clog2(m + 1));
    endfunction

endpackage

// File: rtl/seq_down_cnt.sv
// Loadable saturating down-counter used to time each sequencer phase.
//   clk   : clock
//   load  : load value on the next posedge (takes priority over counting)
//   value : count to load; the phase ends once the count reaches zero
//   zero  : count equals zero (combinational)
module seq_down_cnt #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Decrement until zero, then hold; never wraps.
    always_ff @(posedge clk) begin
        if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rst_ce_sequencer.sv
// Sequences a downstream reset / clock-enable pair: rst_o for RST_CYCLES,
// GAP_CYCLES idle, ce_o for CE_MIN_CYCLES, then ce_o follows run_en.
//   clk        : clock
//   rst        : synchronous active-high reset
//   sw_rst_req : soft-reset request, restarts the sequence
//   run_en     : clock-enable level once in RUN
//   rst_o      : downstream reset (registered)
//   ce_o       : downstream clock enable (registered)
//   busy       : sequence in progress (registered)
//   done       : one-cycle pulse on entry to RUN (registered)
module rst_ce_sequencer
    import rst_ce_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 2,
    parameter int unsigned GAP_CYCLES    = 0,
    parameter int unsigned CE_MIN_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_rst_req,
    input  logic run_en,
    output logic rst_o,
    output logic ce_o,
    output logic busy,
    output logic done
);

    localparam int unsigned CNT_W = cnt_width(RST_CYCLES, GAP_CYCLES, CE_MIN_CYCLES);

    // The counter is loaded with length-1 so zero marks the last cycle of a phase.
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CE_LOAD  = CNT_W'(CE_MIN_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_value;
    logic              cnt_zero;
    logic              rst_o_next;
    logic              ce_o_next;
    logic              busy_next;
    logic              done_next;

    seq_down_cnt #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .load  (cnt_load),
        .value (cnt_value),
        .zero  (cnt_zero)
    );

    // Next-state, counter reload and next output values.
    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_value  = RST_LOAD;

        if (rst || sw_rst_req) begin
            // A request overrides any final count, including the one that would raise done.
            state_next = RESET;
            cnt_load   = 1'b1;
            cnt_value  = RST_LOAD;
        end else begin
            case (state)
                RESET: begin
                    if (cnt_zero) begin
                        cnt_load = 1'b1;
                        if (GAP_CYCLES > 0) begin
                            state_next = GAP;
                            cnt_value  = GAP_LOAD;
                        end else begin
                            state_next = ENABLE;
                            cnt_value  = CE_LOAD;
                        end
                    end
                end
                GAP: begin
                    if (cnt_zero) begin
                        state_next = ENABLE;
                        cnt_load   = 1'b1;
                        cnt_value  = CE_LOAD;
                    end
                end
                ENABLE: begin
                    if (cnt_zero) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    state_next = RUN;
                end
                default: begin
                    state_next = RESET;
                    cnt_load   = 1'b1;
                    cnt_value  = RST_LOAD;
                end
            endcase
        end

        rst_o_next = (state_next == RESET);
        ce_o_next  = (state_next == ENABLE) || ((state_next == RUN) && run_en);
        busy_next  = (state_next != RUN);
        done_next  = (state == ENABLE) && (state_next == RUN);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET;
            rst_o <= 1'b1;
            ce_o  <= 1'b0;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            rst_o <= rst_o_next;
            ce_o  <= ce_o_next;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

    // Downstream reset and enable must never overlap.
    a_no_overlap: assert property (@(posedge clk) !(rst_o && ce_o));

endmodule
